board_level_frame_buffer_ctrl: RTL

Frame-level controller behind `board_level_data_receiver`. It buffers each received frame byte-by-byte into an on-chip circular RAM and releases only frames whose CRC passed. Frames with a CRC error, an overflow, excess length or an abort are rolled back. Committed frames are presented downstream as a byte stream with valid/ready handshake and a last-byte marker, so consumers never see partial or corrupt frames.

---
 rtl/board_level_frame_buffer_ctrl_pkg.sv | 26 ++
 rtl/board_level_frame_buffer_ctrl_frame_buffer_ram.sv | 32 +++
 rtl/board_level_frame_buffer_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/board_level_frame_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : board_level_frame_buffer_ctrl_pkg
// Brief  : Shared definitions for the frame buffer controller: FSM state
//          encoding, RAM entry layout and a saturating counter helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package board_level_frame_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } fsm_state_t;

  // RAM entry is {last, data}; the last flag sits above the payload byte.
  localparam int LAST_BIT = 8;
  localparam int ENTRY_W  = LAST_BIT + 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_level_frame_buffer_ctrl_frame_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module : frame_buffer_ram
// Brief  : Simple dual-port RAM, one write port and one registered read port.
// Ports  : clk                        - clock
//          wr_en / wr_addr / wr_data  - write port
//          rd_en / rd_addr            - read request
//          rd_data                    - read data, valid the cycle after rd_en
// Rev    : 1.0  initial release
// ============================================================================
module frame_buffer_ram #(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/board_level_frame_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : board_level_frame_buffer_ctrl
// Brief  : Buffers received frames in a circular RAM and releases only frames
//          whose CRC passed, as a valid/ready byte stream with a last marker.
// Ports  : clk, rst (sync, active-low)
//          rx_frame_start/rx_frame_end/rx_data/rx_valid/rx_error - receiver
//          out_data/out_last/out_valid/out_ready                 - stream out
//          frames_ok/frames_dropped                              - counters
// Rev    : 1.0  initial release
// ============================================================================
module board_level_frame_buffer_ctrl
  import board_level_frame_buffer_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MAX_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_frame_start,
  input  logic       rx_frame_end,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] frames_ok,
  output logic [7:0] frames_dropped
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int LEN_W = ADDR_W + 2;
  localparam logic [PTR_W-1:0] FULL_LVL  = PTR_W'(1 << ADDR_W);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  fsm_state_t state, state_nxt;

  logic [PTR_W-1:0]   wr_ptr, commit_ptr, rd_ptr, used;
  logic [7:0]         pending;
  logic               pending_vld;
  logic [LEN_W-1:0]   len_cnt, len_inc;
  logic               buf_full;

  logic               do_drop, do_write, do_commit, wr_last;
  logic               load_pending, clr_frame, count_len;
  logic [ENTRY_W-1:0] wr_entry, ram_rdata;

  logic [1:0]         skid_cnt, skid_cnt_nxt;
  logic [ENTRY_W-1:0] skid0, skid1, lane0, lane1;
  logic               rd_inflight, rd_issue, pop;

  assign used     = wr_ptr - rd_ptr;
  assign buf_full = (used == FULL_LVL);
  assign len_inc  = len_cnt + 1'b1;
  assign wr_entry = {wr_last, pending};

  // ---------------- write-side FSM: next state and control strobes --------
  always_comb begin
    state_nxt    = state;
    do_drop      = 1'b0;
    do_write     = 1'b0;
    do_commit    = 1'b0;
    wr_last      = 1'b0;
    load_pending = 1'b0;
    clr_frame    = 1'b0;
    count_len    = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_frame_start) begin
            clr_frame = 1'b1;
            state_nxt = ST_RECV;
          end
        end
        ST_RECV: begin
          if (rx_frame_start) begin
            // abort: drop what was gathered, restart a fresh frame
            do_drop   = 1'b1;
            clr_frame = 1'b1;
          end else if (rx_frame_end) begin
            if (rx_error || !pending_vld || buf_full) begin
              do_drop = 1'b1;
            end else begin
              do_write  = 1'b1;
              wr_last   = 1'b1;
              do_commit = 1'b1;
            end
            state_nxt = ST_IDLE;
          end else begin
            count_len = 1'b1;
            if (len_inc > MAX_LEN_C || (pending_vld && buf_full)) begin
              do_drop   = 1'b1;
              state_nxt = ST_DISCARD;
            end else begin
              do_write     = pending_vld;
              load_pending = 1'b1;
            end
          end
        end
        ST_DISCARD: begin
          if (rx_frame_start) begin
            clr_frame = 1'b1;
            state_nxt = ST_RECV;
          end else if (rx_frame_end) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- write-side datapath ------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      pending        <= 8'h00;
      pending_vld    <= 1'b0;
      len_cnt        <= '0;
      frames_ok      <= 8'h00;
      frames_dropped <= 8'h00;
    end else begin
      if (clr_frame) begin
        pending_vld <= 1'b0;
        len_cnt     <= '0;
      end else if (count_len) begin
        len_cnt <= len_inc;
      end
      if (load_pending) begin
        pending     <= rx_data;
        pending_vld <= 1'b1;
      end
      if (do_drop) begin
        wr_ptr         <= commit_ptr;
        pending_vld    <= 1'b0;
        frames_dropped <= sat_inc(frames_dropped);
      end else if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (do_commit) begin
          commit_ptr <= wr_ptr + 1'b1;
          frames_ok  <= sat_inc(frames_ok);
        end
      end
    end
  end

  frame_buffer_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (do_write),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_entry),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_rdata)
  );

  // ---------------- read side: 2-entry skid fed by the registered RAM ------
  // Ordered list of available bytes is skid0, skid1, then the RAM output when
  // a read is in flight. The head bypasses straight from the RAM when the
  // skid is empty, which gives the two-cycle commit-to-valid latency.
  always_comb begin
    lane0        = (skid_cnt != 2'd0) ? skid0 : ram_rdata;
    lane1        = (skid_cnt == 2'd2) ? skid1 : ram_rdata;
    out_valid    = (skid_cnt != 2'd0) || rd_inflight;
    out_data     = out_valid ? lane0[7:0] : 8'h00;
    out_last     = out_valid ? lane0[LAST_BIT] : 1'b0;
    pop          = out_valid && out_ready;
    skid_cnt_nxt = skid_cnt + 2'(rd_inflight) - 2'(pop);
    // a new read may only be issued if its data will have a slot to land in
    rd_issue     = (rd_ptr != commit_ptr) && (skid_cnt_nxt < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
      skid_cnt    <= 2'd0;
      skid0       <= '0;
      skid1       <= '0;
    end else begin
      rd_inflight <= rd_issue;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      skid_cnt <= skid_cnt_nxt;
      skid0    <= pop ? lane1 : lane0;
      skid1    <= lane1;
    end
  end

endmodule
`default_nettype wire
